instr_fetch_unit: RTL

Instruction fetch unit that sits on the other side of the program counter register: it consumes the registered `pc`, fetches the word at that address from instruction memory over a request/grant/response handshake, and drives `pcnext` back into the PC register. The PC register loads `pcnext` on every clock edge, so this block stalls fetch by returning `pcnext = pc`. Fetched words are handed to decode through a one-entry valid/ready output buffer. Branch and jump redirects from execute are also handled here.

---
 rtl/instr_fetch_unit.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Fetches the instruction at the registered PC over a req/gnt/rvalid memory
// handshake and feeds the PC register back through pcnext. The PC register
// loads pcnext every cycle, so a stall is simply pcnext = pc. Fetched words go
// to decode through a one-entry valid/ready buffer. Execute redirects flush
// the buffer and any in-flight fetch.
//
// Optional feature macro: IFU_ALIGN_CHECK_EN
//   defined   : a launch from a misaligned pc issues no memory request and
//               instead buffers NOP_INSTR with fetch_fault=1
//   undefined : fetch_fault is tied low and imem_addr[1:0] is forced to 0
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   pc                current PC register value
//   pcnext            next PC (combinational)
//   imem_req/addr     fetch request and address (held until imem_gnt)
//   imem_gnt          request accepted
//   imem_rvalid/rdata fetch response
//   redirect_valid/pc taken branch/jump from execute
//   instr_valid/ready output buffer handshake to decode
//   instr, instr_pc   buffered instruction and its address
//   fetch_fault       buffer entry is a misaligned-fetch fault
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] NOP_INSTR = XLEN'('h13)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pcnext,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic            fetch_fault
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DROP
    } state_e;

    state_e          state_q, state_d;
    logic            kill_q, kill_d;
    logic [XLEN-1:0] req_addr_q, req_addr_d;
    logic            buf_valid_q, buf_valid_d;
    logic [XLEN-1:0] buf_instr_q, buf_instr_d;
    logic [XLEN-1:0] buf_pc_q, buf_pc_d;
    logic            buf_load;
    logic            load_fault;
    logic            launch_ok;

    // A new fetch may start only when its response has somewhere to land.
    assign launch_ok = (!buf_valid_q || instr_ready) && !redirect_valid;

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        kill_d     = kill_q;
        req_addr_d = req_addr_q;
        buf_load   = 1'b0;
        load_fault = 1'b0;
        pcnext     = pc;

        unique case (state_q)
            S_IDLE: begin
                if (launch_ok) begin
`ifdef IFU_ALIGN_CHECK_EN
                    if (pc[1:0] != 2'b00) begin
                        // Fault goes straight into the buffer; PC holds and
                        // the fault repeats until a redirect moves the PC.
                        buf_load   = 1'b1;
                        load_fault = 1'b1;
                    end else begin
                        req_addr_d = pc;
                        state_d    = S_REQ;
                    end
`else
                    req_addr_d = pc;
                    state_d    = S_REQ;
`endif
                end
            end
            S_REQ: begin
                if (imem_gnt) begin
                    kill_d  = 1'b0;
                    state_d = (kill_q || redirect_valid) ? S_DROP : S_WAIT;
                    if (!kill_q) begin
                        pcnext = pc + XLEN'(4);
                    end
                end else if (redirect_valid) begin
                    // Request cannot be withdrawn; remember to drop its data.
                    kill_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    state_d  = S_IDLE;
                    buf_load = !redirect_valid;
                end else if (redirect_valid) begin
                    state_d = S_DROP;
                end
            end
            S_DROP: begin
                if (imem_rvalid) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (redirect_valid) begin
            pcnext = redirect_pc;
        end
    end

    // Output buffer: a redirect flush beats a same-cycle load, and a load
    // beats a same-cycle drain.
    always_comb begin
        buf_valid_d = buf_valid_q;
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;
        if (redirect_valid) begin
            buf_valid_d = 1'b0;
        end else if (buf_load) begin
            buf_valid_d = 1'b1;
            buf_instr_d = load_fault ? NOP_INSTR : imem_rdata;
            buf_pc_d    = load_fault ? pc : req_addr_q;
        end else if (buf_valid_q && instr_ready) begin
            buf_valid_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            kill_q      <= 1'b0;
            req_addr_q  <= '0;
            buf_valid_q <= 1'b0;
            buf_instr_q <= '0;
            buf_pc_q    <= '0;
        end else begin
            state_q     <= state_d;
            kill_q      <= kill_d;
            req_addr_q  <= req_addr_d;
            buf_valid_q <= buf_valid_d;
            buf_instr_q <= buf_instr_d;
            buf_pc_q    <= buf_pc_d;
        end
    end

`ifdef IFU_ALIGN_CHECK_EN
    logic buf_fault_q, buf_fault_d;

    always_comb begin
        buf_fault_d = buf_fault_q;
        if (!redirect_valid && buf_load) begin
            buf_fault_d = load_fault;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_fault_q <= 1'b0;
        end else begin
            buf_fault_q <= buf_fault_d;
        end
    end

    assign fetch_fault = buf_fault_q;
    assign imem_addr   = req_addr_q;
`else
    assign fetch_fault = 1'b0;
    assign imem_addr   = {req_addr_q[XLEN-1:2], 2'b00};
`endif

    assign imem_req    = (state_q == S_REQ);
    assign instr_valid = buf_valid_q;
    assign instr       = buf_instr_q;
    assign instr_pc    = buf_pc_q;

endmodule
